icache: RTL



---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_array.sv | 45 ++++
 rtl/icache.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ICACHE_LINE_SIZ = 16;
    localparam int ICACHE_LINE_WID = ICACHE_LINE_SIZ * 8;
    localparam int ADDR_WID        = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_REPLY = 2'd2
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the icache: one combinational read port, one write port.
module icache_array #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 24,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tags [DEPTH];
    logic [DATA_W-1:0] data [DEPTH];

    // Only the valid bits need reset; tag/data are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: FSM and address split; storage in icache_array.
// Optional hit/miss counters enabled by defining ICACHE_PERF_EN.
module icache
    import icache_pkg::*;
#(
    parameter int LINE_BYTES = ICACHE_LINE_SIZ,
    parameter int LINES      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    fetch_en,
    input  logic [ADDR_WID-1:0]     fetch_pc,
    output logic                    inst_valid,
    output logic [31:0]             inst,
    output logic                    if_en,
    output logic [ADDR_WID-1:0]     if_pc,
    input  logic                    if_done,
`ifdef ICACHE_PERF_EN
    input  logic [LINE_BYTES*8-1:0] if_data,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`else
    input  logic [LINE_BYTES*8-1:0] if_data
`endif
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_WID - OFF_W - IDX_W;
    localparam int WSEL_W = (OFF_W > 2) ? OFF_W - 2 : 1;
    localparam int DATA_W = LINE_BYTES * 8;

    state_t state, state_nx;

    logic              iv_q;
    logic              kill;
    logic [WSEL_W-1:0] miss_wsel;

    logic [IDX_W-1:0]  pc_idx, miss_idx;
    logic [TAG_W-1:0]  pc_tag, miss_tag;
    logic [WSEL_W-1:0] pc_wsel;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit, accept, refill, reply_ok;
    logic [31:0]       hit_word, fill_word;

    assign pc_idx   = fetch_pc[OFF_W +: IDX_W];
    assign pc_tag   = fetch_pc[ADDR_WID-1 -: TAG_W];
    assign miss_idx = if_pc[OFF_W +: IDX_W];
    assign miss_tag = if_pc[ADDR_WID-1 -: TAG_W];

    generate
        if (OFF_W > 2) begin : g_wsel
            assign pc_wsel = fetch_pc[OFF_W-1:2];
        end else begin : g_wsel_one
            assign pc_wsel = '0;
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], if_pc[OFF_W-1:0]};

    icache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pc_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (refill),
        .wr_idx   (miss_idx),
        .wr_tag   (miss_tag),
        .wr_data  (if_data)
    );

    assign hit       = rd_valid && (rd_tag == pc_tag);
    // No new lookup while the previous reply pulse is still on the bus.
    assign accept    = (state == ST_IDLE) && fetch_en && !rollback && !iv_q;
    assign refill    = rdy && (state == ST_MISS) && if_done;
    assign reply_ok  = !kill && !rollback;
    assign hit_word  = rd_data[{pc_wsel, 5'b0} +: 32];
    assign fill_word = if_data[{miss_wsel, 5'b0} +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept && !hit) state_nx = ST_MISS;
            ST_MISS:  if (if_done)        state_nx = reply_ok ? ST_REPLY : ST_IDLE;
            ST_REPLY:                     state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        if_en      = (state == ST_MISS);
        inst_valid = iv_q && rdy && !rollback;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iv_q      <= 1'b0;
            inst      <= '0;
            if_pc     <= '0;
            kill      <= 1'b0;
            miss_wsel <= '0;
        end else if (rdy) begin
            iv_q <= 1'b0;
            if (accept && hit) begin
                iv_q <= 1'b1;
                inst <= hit_word;
            end else if (accept) begin
                if_pc     <= {fetch_pc[ADDR_WID-1:OFF_W], {OFF_W{1'b0}}};
                miss_wsel <= pc_wsel;
                kill      <= 1'b0;
            end
            if (state == ST_MISS) begin
                if (rollback) kill <= 1'b1;
                if (if_done && reply_ok) begin
                    iv_q <= 1'b1;
                    inst <= fill_word;
                end
            end
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy && accept) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
